// File: rtl/delay_tap_ctrl_if.sv
// Command and status interface between the read-training FSM (master) and delay_tap_ctrl (slave).
interface delay_tap_ctrl_if #(
    parameter int unsigned TAP_BITS = 7
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [TAP_BITS-1:0] cmd_tap;
    logic                done;
    logic                err;
    logic                cal_ok;
    logic [TAP_BITS-1:0] cur_tap;

    modport master (
        output cmd_valid, cmd_op, cmd_tap,
        input  cmd_ready, done, err, cal_ok, cur_tap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tap,
        output cmd_ready, done, err, cal_ok, cur_tap
    );
endinterface

// File: rtl/delay_tap_ctrl.sv
// Sequences one ECP5 DELAYF dynamic delay line: reload to default tap, step to an absolute
// tap, or sweep the taps to find the passing data window and centre the tap inside it.
module delay_tap_ctrl #(
    parameter int unsigned TAP_BITS      = 7,
    parameter int unsigned MAX_TAP       = 127,
    parameter int unsigned DEFAULT_TAP   = 0,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    delay_tap_ctrl_if.slave  cmd,
    input  logic             sample_ok,
    output logic             dly_loadn,
    output logic             dly_move,
    output logic             dly_direction,
    input  logic             dly_cflag
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 2);
    localparam int unsigned SUM_W = TAP_BITS + 1;

    localparam logic [TAP_BITS-1:0] MAX_T       = TAP_BITS'(MAX_TAP);
    localparam logic [TAP_BITS-1:0] DEF_T       = TAP_BITS'(DEFAULT_TAP);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_SWEEP = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STEP_HI, S_STEP_LO, S_SETTLE, S_SAMPLE, S_CENTER, S_FINISH
    } state_t;

    // What the current state sequence is working on; selects where SETTLE leads.
    typedef enum logic [2:0] {
        M_NONE, M_BOOT, M_LOAD, M_SET, M_SWEEP, M_CENTER
    } mode_t;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAP_BITS-1:0] tgt_q, tgt_d;
    logic [TAP_BITS-1:0] lo_q, lo_d;
    logic [TAP_BITS-1:0] hi_q, hi_d;
    logic                found_q, found_d;
    logic [TAP_BITS-1:0] cur_tap_q, cur_tap_d;
    logic                dir_q, dir_d;
    logic                err_q, err_d;
    logic                cal_ok_q, cal_ok_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                loadn_q, loadn_d;
    logic                move_q, move_d;

    logic                accept;
    logic [TAP_BITS-1:0] set_tgt;
    logic [SUM_W-1:0]    win_sum;
    logic [TAP_BITS-1:0] win_mid;

    assign accept  = cmd.cmd_valid & ready_q;
    assign set_tgt = ({1'b0, cmd.cmd_tap} > SUM_W'(MAX_TAP)) ? MAX_T : cmd.cmd_tap;
    // Window sum carries one extra bit so lo+hi near MAX_TAP cannot wrap.
    assign win_sum = SUM_W'(lo_q) + SUM_W'(hi_q);
    assign win_mid = win_sum[SUM_W-1:1];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= M_BOOT;
            cnt_q     <= '0;
            tgt_q     <= DEF_T;
            lo_q      <= '0;
            hi_q      <= '0;
            found_q   <= 1'b0;
            cur_tap_q <= DEF_T;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            cal_ok_q  <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            loadn_q   <= 1'b1;
            move_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            found_q   <= found_d;
            cur_tap_q <= cur_tap_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            cal_ok_q  <= cal_ok_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            loadn_q   <= loadn_d;
            move_q    <= move_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tgt_d     = tgt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        found_d   = found_q;
        cur_tap_d = cur_tap_q;
        dir_d     = dir_q;
        err_d     = err_q;
        cal_ok_d  = cal_ok_q;

        case (state_q)
            S_IDLE: begin
                if (mode_q == M_BOOT) begin
                    state_d = S_LOAD;
                end else if (accept) begin
                    err_d = 1'b0;
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            mode_d   = M_LOAD;
                            cal_ok_d = 1'b0;
                            state_d  = S_LOAD;
                        end
                        OP_SET: begin
                            mode_d = M_SET;
                            tgt_d  = set_tgt;
                            if (set_tgt == cur_tap_q) begin
                                state_d = S_FINISH;
                            end else begin
                                dir_d   = (set_tgt < cur_tap_q);
                                state_d = S_STEP_HI;
                            end
                        end
                        OP_SWEEP: begin
                            mode_d   = M_SWEEP;
                            cal_ok_d = 1'b0;
                            found_d  = 1'b0;
                            state_d  = S_LOAD;
                        end
                        default: begin
                            mode_d  = M_NONE;
                            state_d = S_FINISH;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_SETTLE;
                end
            end
            S_STEP_HI: begin
                // CFLAG means the line is pinned at its limit: the tap did not move.
                if (dly_cflag) begin
                    err_d = 1'b1;
                    if (mode_q == M_SWEEP || mode_q == M_CENTER) begin
                        cal_ok_d = 1'b0;
                    end
                    state_d = S_FINISH;
                end else begin
                    cur_tap_d = dir_q ? (cur_tap_q - TAP_BITS'(1)) : (cur_tap_q + TAP_BITS'(1));
                    state_d   = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    case (mode_q)
                        M_BOOT: begin
                            mode_d  = M_NONE;
                            state_d = S_IDLE;
                        end
                        M_SET: begin
                            if (cur_tap_q == tgt_q) begin
                                state_d = S_FINISH;
                            end else begin
                                dir_d   = (tgt_q < cur_tap_q);
                                state_d = S_STEP_HI;
                            end
                        end
                        M_SWEEP:  state_d = S_SAMPLE;
                        M_CENTER: state_d = S_CENTER;
                        default:  state_d = S_FINISH;
                    endcase
                end
            end
            S_SAMPLE: begin
                if (sample_ok) begin
                    if (!found_q) begin
                        lo_d    = cur_tap_q;
                        found_d = 1'b1;
                    end
                    hi_d = cur_tap_q;
                end
                // Window closes on the first fail after a pass, or on a pass at the last tap.
                if ((found_q && !sample_ok) || (sample_ok && cur_tap_q == MAX_T)) begin
                    state_d = S_CENTER;
                end else if (cur_tap_q == MAX_T) begin
                    err_d    = 1'b1;
                    cal_ok_d = 1'b0;
                    mode_d   = M_LOAD;
                    state_d  = S_LOAD;
                end else begin
                    dir_d   = 1'b0;
                    state_d = S_STEP_HI;
                end
            end
            S_CENTER: begin
                mode_d = M_CENTER;
                if (cur_tap_q == win_mid) begin
                    cal_ok_d = 1'b1;
                    state_d  = S_FINISH;
                end else begin
                    dir_d   = 1'b1;
                    state_d = S_STEP_HI;
                end
            end
            S_FINISH: begin
                mode_d  = M_NONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_LOAD && state_q != S_LOAD) begin
            cur_tap_d = DEF_T;
        end
    end

    // Dwell counter for the multi-cycle LOAD and SETTLE states.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && (state_q == S_LOAD || state_q == S_SETTLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        ready_d = (state_d == S_IDLE) && (mode_d != M_BOOT);
        done_d  = (state_q == S_FINISH);
        loadn_d = (state_d != S_LOAD);
        move_d  = (state_d == S_STEP_HI);
    end

    assign cmd.cmd_ready = ready_q;
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;
    assign cmd.cal_ok    = cal_ok_q;
    assign cmd.cur_tap   = cur_tap_q;
    assign dly_loadn     = loadn_q;
    assign dly_move      = move_q;
    assign dly_direction = dir_q;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed bench for delay_tap_ctrl: reset/boot load, SET stepping and clamp, CFLAG stop,
// sweeps with various windows, and reset in the middle of a MOVE pulse.
module tb_delay_tap_ctrl;

    localparam int unsigned TAP_BITS = 8;
    localparam logic [1:0]  OP_LOAD  = 2'd0;
    localparam logic [1:0]  OP_SET   = 2'd1;
    localparam logic [1:0]  OP_SWEEP = 2'd2;
    localparam logic [1:0]  OP_NOP   = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    logic sample_ok;
    logic dly_loadn;
    logic dly_move;
    logic dly_direction;
    logic dly_cflag;

    int win_lo   = 1000;
    int win_hi   = -1;
    int cflag_at = -1;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int accepts  = 0;
    int overlaps = 0;
    int mv_t[$];
    bit mv_d[$];

    int mv_from;
    int acc_from;

    delay_tap_ctrl_if #(.TAP_BITS(TAP_BITS)) cmd ();

    delay_tap_ctrl #(
        .TAP_BITS      (TAP_BITS),
        .MAX_TAP       (127),
        .DEFAULT_TAP   (0),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .sample_ok     (sample_ok),
        .dly_loadn     (dly_loadn),
        .dly_move      (dly_move),
        .dly_direction (dly_direction),
        .dly_cflag     (dly_cflag)
    );

    always #5 clk = ~clk;

    // Simple delay-line model: passing window and a CFLAG limit at one tap.
    assign sample_ok = (int'(cmd.cur_tap) >= win_lo) && (int'(cmd.cur_tap) <= win_hi);
    assign dly_cflag = (cflag_at >= 0) && (int'(cmd.cur_tap) == cflag_at);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dly_move) begin
            mv_t.push_back(cyc);
            mv_d.push_back(dly_direction);
        end
        if (cmd.cmd_valid && cmd.cmd_ready) accepts <= accepts + 1;
        if (!dly_loadn && dly_move) overlaps <= overlaps + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic move_stats(output int up, output int dn, output int bad_gap);
        up = 0;
        dn = 0;
        bad_gap = 0;
        for (int i = mv_from; i < mv_t.size(); i++) begin
            if (mv_d[i]) dn++;
            else up++;
            if (i > mv_from && (mv_t[i] - mv_t[i-1]) != 6) bad_gap++;
        end
    endtask

    // Issue one command from a negedge; returns at the first negedge after acceptance.
    task automatic issue(input string tag, input logic [1:0] op, input int tap);
        int guard = 0;
        mv_from  = mv_t.size();
        acc_from = accepts;
        cmd.cmd_op    = op;
        cmd.cmd_tap   = 8'(tap);
        cmd.cmd_valid = 1'b1;
        while (!cmd.cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " ready"}, 32'(cmd.cmd_ready), 1);
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 1;
        while (!cmd.done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " done"}, 32'(cmd.done), 1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input int tap,
                           input int budget, output int lat);
        issue(tag, op, tap);
        wait_done(tag, budget, lat);
    endtask

    initial begin
        int lat, up, dn, bad, guard;

        rst_n = 1'b0;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = OP_NOP;
        cmd.cmd_tap   = '0;
        repeat (3) @(negedge clk);

        check("rst ready",  32'(cmd.cmd_ready), 0);
        check("rst done",   32'(cmd.done), 0);
        check("rst err",    32'(cmd.err), 0);
        check("rst cal_ok", 32'(cmd.cal_ok), 0);
        check("rst tap",    32'(cmd.cur_tap), 0);
        check("rst loadn",  32'(dly_loadn), 1);
        check("rst move",   32'(dly_move), 0);
        check("rst dir",    32'(dly_direction), 0);

        // Automatic LOAD after release: loadn low in cycles 1-2, ready in cycle 7, no done.
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("boot loadn c%0d", i), 32'(dly_loadn), 32'(i >= 3));
            check($sformatf("boot ready c%0d", i), 32'(cmd.cmd_ready), 32'(i >= 7));
            check($sformatf("boot done c%0d", i),  32'(cmd.done), 0);
        end

        run_cmd("nop", OP_NOP, 0, 50, lat);
        check("nop lat", 32'(lat), 2);
        check("nop tap", 32'(cmd.cur_tap), 0);

        run_cmd("set0", OP_SET, 0, 50, lat);
        move_stats(up, dn, bad);
        check("set0 lat", 32'(lat), 2);
        check("set0 moves", 32'(up + dn), 0);

        run_cmd("set5", OP_SET, 5, 200, lat);
        move_stats(up, dn, bad);
        check("set5 lat", 32'(lat), 32);
        check("set5 up", 32'(up), 5);
        check("set5 dn", 32'(dn), 0);
        check("set5 gap", 32'(bad), 0);
        check("set5 tap", 32'(cmd.cur_tap), 5);
        check("set5 err", 32'(cmd.err), 0);

        run_cmd("set2", OP_SET, 2, 200, lat);
        move_stats(up, dn, bad);
        check("set2 lat", 32'(lat), 20);
        check("set2 dn", 32'(dn), 3);
        check("set2 up", 32'(up), 0);
        check("set2 gap", 32'(bad), 0);
        check("set2 tap", 32'(cmd.cur_tap), 2);

        run_cmd("set200", OP_SET, 200, 2000, lat);
        move_stats(up, dn, bad);
        check("set200 lat", 32'(lat), 752);
        check("set200 up", 32'(up), 125);
        check("set200 tap", 32'(cmd.cur_tap), 127);
        check("set200 err", 32'(cmd.err), 0);

        run_cmd("load", OP_LOAD, 0, 50, lat);
        check("load lat", 32'(lat), 8);
        check("load tap", 32'(cmd.cur_tap), 0);

        // CFLAG asserted at tap 40 stops the SET there with err.
        cflag_at = 40;
        run_cmd("cflag", OP_SET, 100, 1000, lat);
        move_stats(up, dn, bad);
        check("cflag lat", 32'(lat), 243);
        check("cflag up", 32'(up), 41);
        check("cflag tap", 32'(cmd.cur_tap), 40);
        check("cflag err", 32'(cmd.err), 1);
        cflag_at = -1;

        run_cmd("load2", OP_LOAD, 0, 50, lat);
        check("load2 err", 32'(cmd.err), 0);

        win_lo = 20;
        win_hi = 36;
        run_cmd("sweep20", OP_SWEEP, 0, 3000, lat);
        move_stats(up, dn, bad);
        check("sweep20 lat", 32'(lat), 332);
        check("sweep20 up", 32'(up), 37);
        check("sweep20 dn", 32'(dn), 9);
        check("sweep20 tap", 32'(cmd.cur_tap), 28);
        check("sweep20 cal", 32'(cmd.cal_ok), 1);
        check("sweep20 err", 32'(cmd.err), 0);

        win_lo = 1000;
        win_hi = -1;
        run_cmd("sweepnone", OP_SWEEP, 0, 3000, lat);
        move_stats(up, dn, bad);
        check("sweepnone lat", 32'(lat), 904);
        check("sweepnone up", 32'(up), 127);
        check("sweepnone tap", 32'(cmd.cur_tap), 0);
        check("sweepnone cal", 32'(cmd.cal_ok), 0);
        check("sweepnone err", 32'(cmd.err), 1);
        repeat (3) @(negedge clk);
        check("sweepnone err held", 32'(cmd.err), 1);

        win_lo = 120;
        win_hi = 127;
        run_cmd("sweep120", OP_SWEEP, 0, 3000, lat);
        move_stats(up, dn, bad);
        check("sweep120 lat", 32'(lat), 927);
        check("sweep120 dn", 32'(dn), 4);
        check("sweep120 tap", 32'(cmd.cur_tap), 123);
        check("sweep120 cal", 32'(cmd.cal_ok), 1);
        check("sweep120 err", 32'(cmd.err), 0);

        // Reset while MOVE is high in the middle of a SET.
        run_cmd("pre", OP_LOAD, 0, 50, lat);
        issue("midset", OP_SET, 10);
        guard = 0;
        while (!(dly_move && cmd.cur_tap == 8'd2) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("midrst move seen", 32'(dly_move), 1);
        rst_n = 1'b0;
        cmd.cmd_op    = OP_SET;
        cmd.cmd_tap   = 8'd3;
        cmd.cmd_valid = 1'b1;
        @(negedge clk);
        check("midrst move", 32'(dly_move), 0);
        check("midrst loadn", 32'(dly_loadn), 1);
        check("midrst tap", 32'(cmd.cur_tap), 0);
        rst_n = 1'b1;
        mv_from  = mv_t.size();
        acc_from = accepts;
        @(negedge clk);
        check("midrst boot loadn", 32'(dly_loadn), 0);
        guard = 0;
        while (!cmd.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midrst ready", 32'(cmd.cmd_ready), 1);
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        wait_done("midrst set3", 200, lat);
        move_stats(up, dn, bad);
        check("midrst accepts", 32'(accepts - acc_from), 1);
        check("midrst up", 32'(up), 3);
        check("midrst final tap", 32'(cmd.cur_tap), 3);

        check("loadn/move overlap", 32'(overlaps), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
